// File: rtl/rom_dump_sequencer_if.sv
//------------------------------------------------------------------------------
// rom_dump_sequencer_if
//
// Purpose : byte stream from the ROM dump sequencer to the UART transmitter.
//           Standard valid/ready handshake, one ASCII byte per transfer.
//
// Signals :
//   tx_data   8  ASCII byte presented by the sequencer
//   tx_valid  1  tx_data holds a byte waiting to be taken
//   tx_ready  1  transmitter takes the byte on this clock edge
//
// Modports:
//   master  sequencer side (drives tx_data/tx_valid, observes tx_ready)
//   slave   transmitter side
//------------------------------------------------------------------------------
interface rom_dump_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/rom_dump_sequencer.sv
//------------------------------------------------------------------------------
// rom_dump_sequencer
//
// Purpose : walks rom_reader through its whole address space and streams one
//           ASCII record "AAA:DD<CR><LF>" per address to a UART transmitter.
//           For every address it waits SETTLE_CYCLES clocks, samples the
//           address/data lines, emits the record, then pulses
//           increment_address for one clock. The dump stops after the record
//           whose captured address is all ones.
//
// Parameters:
//   DATA_WIDTH     width of data_line    (8 for 3604, 4 for 3601)
//   ADDRESS_WIDTH  width of address_line (9 for 3604, 8 for 3601), 1..12
//   SETTLE_CYCLES  clocks waited per address before sampling, 1..255
//
// Ports:
//   clk                in   system clock
//   reset_n            in   asynchronous reset, active-high (1 = reset)
//   start              in   level, accepted only when idle or done
//   address_line       in   current address from rom_reader
//   data_line          in   current data from rom_reader
//   increment_address  out  one-clock step pulse to rom_reader
//   busy               out  dump in progress
//   done               out  dump complete, held until next start or reset
//   tx                 if   byte stream to transmitter (master modport)
//
// Build option:
//   ROM_DUMP_CHECKSUM_EN  when defined, an 8-bit sum of all data values is
//                         appended as a trailer record "S:HH<CR><LF>".
//------------------------------------------------------------------------------
module rom_dump_sequencer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] address_line,
    input  logic [DATA_WIDTH-1:0]    data_line,
    output logic                     increment_address,
    output logic                     busy,
    output logic                     done,
    rom_dump_sequencer_if.master     tx
);

    localparam int AD      = (ADDRESS_WIDTH + 3) / 4;
    localparam int DD      = (DATA_WIDTH + 3) / 4;
    localparam int REC_LEN = AD + DD + 3;
    // Index must also reach 5 for the six-byte checksum trailer.
    localparam int IDX_W   = (REC_LEN > 6) ? $clog2(REC_LEN) : 3;

    localparam logic [IDX_W-1:0]         REC_END = IDX_W'(REC_LEN - 1);
    localparam logic [7:0]               CNT_END = 8'(SETTLE_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_EMIT,
        S_STEP,
`ifdef ROM_DUMP_CHECKSUM_EN
        S_CHKSUM,
`endif
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [7:0]               r_cnt;
    logic [IDX_W-1:0]         r_idx;
    logic [ADDRESS_WIDTH-1:0] r_cap_addr;
    logic [DATA_WIDTH-1:0]    r_cap_data;
    logic [7:0]               r_tx_data;
    logic                     r_tx_valid;
    logic                     r_inc;
    logic                     r_busy;
    logic                     r_done;
`ifdef ROM_DUMP_CHECKSUM_EN
    logic [7:0]               r_sum;
`endif

    logic w_tx_fire;
    logic w_last_addr;

    assign w_tx_fire   = r_tx_valid && tx.tx_ready;
    // Termination is decided on the address rom_reader actually reported.
    assign w_last_addr = (r_cap_addr == LAST);

    assign tx.tx_data        = r_tx_data;
    assign tx.tx_valid       = r_tx_valid;
    assign increment_address = r_inc;
    assign busy              = r_busy;
    assign done              = r_done;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + 8'(nib)) : (8'h37 + 8'(nib));
    endfunction

    // Byte idx of the record for (addr, data). Values are zero-extended to a
    // whole number of nibbles so the top digit is well defined.
    function automatic logic [7:0] rec_byte(input logic [ADDRESS_WIDTH-1:0] addr,
                                            input logic [DATA_WIDTH-1:0]    data,
                                            input logic [IDX_W-1:0]         idx);
        logic [AD*4-1:0] a_ext;
        logic [DD*4-1:0] d_ext;
        int              i;
        a_ext = '0;
        a_ext[ADDRESS_WIDTH-1:0] = addr;
        d_ext = '0;
        d_ext[DATA_WIDTH-1:0] = data;
        i = int'(idx);
        if (i < AD)
            return hex_char(4'(a_ext >> (4 * (AD - 1 - i))));
        else if (i == AD)
            return 8'h3A;
        else if (i <= AD + DD)
            return hex_char(4'(d_ext >> (4 * (AD + DD - i))));
        else if (i == AD + DD + 1)
            return 8'h0D;
        else
            return 8'h0A;
    endfunction

`ifdef ROM_DUMP_CHECKSUM_EN
    function automatic logic [7:0] chk_byte(input logic [7:0]       sum,
                                            input logic [IDX_W-1:0] idx);
        int i;
        i = int'(idx);
        if (i == 0)      return 8'h53;
        else if (i == 1) return 8'h3A;
        else if (i == 2) return hex_char(sum[7:4]);
        else if (i == 3) return hex_char(sum[3:0]);
        else if (i == 4) return 8'h0D;
        else             return 8'h0A;
    endfunction
`endif

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_cap_addr <= '0;
            r_cap_data <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_inc      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_SETTLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end

                S_SETTLE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == CNT_END)
                        r_state <= S_CAPTURE;
                end

                // First byte is built from the live lines because the capture
                // registers only update on this same edge.
                S_CAPTURE: begin
                    r_cap_addr <= address_line;
                    r_cap_data <= data_line;
                    r_idx      <= '0;
                    r_tx_data  <= rec_byte(address_line, data_line, '0);
                    r_tx_valid <= 1'b1;
                    r_state    <= S_EMIT;
`ifdef ROM_DUMP_CHECKSUM_EN
                    r_sum      <= r_sum + 8'(data_line);
`endif
                end

                S_EMIT: begin
                    if (w_tx_fire) begin
                        if (r_idx == REC_END) begin
                            r_tx_valid <= 1'b0;
                            if (w_last_addr) begin
`ifdef ROM_DUMP_CHECKSUM_EN
                                r_state    <= S_CHKSUM;
                                r_idx      <= '0;
                                r_tx_data  <= chk_byte(r_sum, '0);
                                r_tx_valid <= 1'b1;
`else
                                r_state    <= S_DONE;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
`endif
                            end else begin
                                r_state <= S_STEP;
                                r_inc   <= 1'b1;
                            end
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_tx_data <= rec_byte(r_cap_addr, r_cap_data, r_idx + 1'b1);
                        end
                    end
                end

                S_STEP: begin
                    r_inc   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_SETTLE;
                end

`ifdef ROM_DUMP_CHECKSUM_EN
                S_CHKSUM: begin
                    if (w_tx_fire) begin
                        if (r_idx == IDX_W'(5)) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_tx_data <= chk_byte(r_sum, r_idx + 1'b1);
                        end
                    end
                end
`endif

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_dump_sequencer.sv
module tb_rom_dump_sequencer;

    localparam int A_AW = 2;
    localparam int A_DW = 8;
    localparam int A_S  = 3;
    localparam int B_AW = 9;
    localparam int B_DW = 4;
    localparam int B_S  = 4;
`ifdef ROM_DUMP_CHECKSUM_EN
    localparam int TRAILER = 1;
`else
    localparam int TRAILER = 0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic rom_rst_a = 1'b0;
    logic rom_rst_b = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int mode_a   = 0;
    int mode_b   = 0;

    // ---------------- rom_reader stand-ins ----------------
    logic [A_AW-1:0] addr_a;
    logic [A_DW-1:0] rom_a [4];
    logic [A_DW-1:0] data_a;
    logic            inc_a, busy_a, done_a;
    logic [B_AW-1:0] addr_b;
    logic [B_DW-1:0] rom_b [512];
    logic [B_DW-1:0] data_b;
    logic            inc_b, busy_b, done_b;

    assign data_a = rom_a[addr_a];
    assign data_b = rom_b[addr_b];

    always_ff @(posedge clk) begin
        if (rom_rst_a)  addr_a <= '0;
        else if (inc_a) addr_a <= addr_a + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rom_rst_b)  addr_b <= '0;
        else if (inc_b) addr_b <= addr_b + 1'b1;
    end

    rom_dump_sequencer_if if_a ();
    rom_dump_sequencer_if if_b ();

    rom_dump_sequencer #(.DATA_WIDTH(A_DW), .ADDRESS_WIDTH(A_AW), .SETTLE_CYCLES(A_S)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .address_line(addr_a), .data_line(data_a),
        .increment_address(inc_a), .busy(busy_a), .done(done_a), .tx(if_a));

    rom_dump_sequencer #(.DATA_WIDTH(B_DW), .ADDRESS_WIDTH(B_AW), .SETTLE_CYCLES(B_S)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .address_line(addr_b), .data_line(data_b),
        .increment_address(inc_b), .busy(busy_b), .done(done_b), .tx(if_b));

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];

    function automatic string hexn(input int v, input int n);
        string lut = "0123456789ABCDEF";
        string r = "";
        for (int k = n - 1; k >= 0; k--) begin
            int d = (v >> (4 * k)) & 15;
            r = {r, lut.substr(d, d)};
        end
        return r;
    endfunction

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Full expected dump: one record per address, then optional checksum.
    task automatic build_exp(input int aw, input int dw, input int rom[$]);
        int sum = 0;
        exp_q.delete();
        for (int a = 0; a < (1 << aw); a++) begin
            push_str({hexn(a, (aw + 3) / 4), ":", hexn(rom[a], (dw + 3) / 4)});
            sum += rom[a];
        end
        if (TRAILER == 1) push_str({"S:", hexn(sum % 256, 2)});
    endtask

    task automatic compare_stream(input string tag, input logic [7:0] got[$]);
        int n;
        check_eq({tag, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    // ---------------- tx_ready driver ----------------
    initial begin
        int ph_a = 0;
        if_a.tx_ready = 1'b1;
        if_b.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode_a)
                0: if_a.tx_ready = 1'b1;
                1: begin if_a.tx_ready = (ph_a == 0); ph_a = (ph_a + 1) % 3; end
                default: if_a.tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode_b == 0) if_b.tx_ready = 1'b1;
            else             if_b.tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stream monitors ----------------
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    int recs_a = 0, pulses_a = 0, since_a = 0;
    int recs_b = 0, pulses_b = 0, since_b = 0;
    logic stall_a = 0, armed_a = 0, prev_inc_a = 0, prev_vld_a = 0;
    logic stall_b = 0, armed_b = 0, prev_inc_b = 0, prev_vld_b = 0;
    logic [7:0] stall_dat_a = 0, stall_dat_b = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            stall_a = 0; armed_a = 0; prev_inc_a = 0; prev_vld_a = 0;
        end else begin
            if (stall_a) begin
                check_eq("a_stall_valid", 32'(if_a.tx_valid), 1);
                check_eq("a_stall_data", 32'(if_a.tx_data), 32'(stall_dat_a));
            end
            stall_a     = if_a.tx_valid && !if_a.tx_ready;
            stall_dat_a = if_a.tx_data;
            if (if_a.tx_valid && if_a.tx_ready) begin
                q_a.push_back(if_a.tx_data);
                if (if_a.tx_data == 8'h0A) recs_a++;
            end
            if (inc_a) begin
                check_eq("a_inc_width", 32'(prev_inc_a), 0);
                pulses_a++; since_a = 0; armed_a = 1;
            end else since_a++;
            if (armed_a && if_a.tx_valid && !prev_vld_a) begin
                check_eq("a_settle_gap", since_a, A_S + 2);
                armed_a = 0;
            end
            prev_inc_a = inc_a;
            prev_vld_a = if_a.tx_valid;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            stall_b = 0; armed_b = 0; prev_inc_b = 0; prev_vld_b = 0;
        end else begin
            if (stall_b) begin
                check_eq("b_stall_valid", 32'(if_b.tx_valid), 1);
                check_eq("b_stall_data", 32'(if_b.tx_data), 32'(stall_dat_b));
            end
            stall_b     = if_b.tx_valid && !if_b.tx_ready;
            stall_dat_b = if_b.tx_data;
            if (if_b.tx_valid && if_b.tx_ready) begin
                q_b.push_back(if_b.tx_data);
                if (if_b.tx_data == 8'h0A) recs_b++;
            end
            if (inc_b) begin
                check_eq("b_inc_width", 32'(prev_inc_b), 0);
                pulses_b++; since_b = 0; armed_b = 1;
            end else since_b++;
            if (armed_b && if_b.tx_valid && !prev_vld_b) begin
                check_eq("b_settle_gap", since_b, B_S + 2);
                armed_b = 0;
            end
            prev_inc_b = inc_b;
            prev_vld_b = if_b.tx_valid;
        end
    end

    // ---------------- sequences ----------------
    task automatic wait_done_a(input string tag, input int budget);
        int n = 0;
        while (!done_a && n < budget) begin @(negedge clk); n++; end
        check_eq({tag, "_done_seen"}, 32'(done_a), 1);
    endtask

    task automatic prep_a();
        rom_rst_a = 1'b1;
        @(negedge clk);
        rom_rst_a = 1'b0;
        q_a.delete(); recs_a = 0; pulses_a = 0;
    endtask

    task automatic check_dump_a(input string tag);
        int rom[$];
        for (int i = 0; i < 4; i++) rom.push_back(int'(rom_a[i]));
        build_exp(A_AW, A_DW, rom);
        compare_stream(tag, q_a);
        check_eq({tag, "_pulses"}, pulses_a, 3);
        check_eq({tag, "_records"}, recs_a, 4 + TRAILER);
        check_eq({tag, "_busy_end"}, 32'(busy_a), 0);
        check_eq({tag, "_done_end"}, 32'(done_a), 1);
    endtask

    task automatic run_a(input string tag);
        prep_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq({tag, "_busy_start"}, 32'(busy_a), 1);
        check_eq({tag, "_done_start"}, 32'(done_a), 0);
        wait_done_a(tag, 2000);
        check_dump_a(tag);
    endtask

    initial begin
        bit found;
        int n;
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy_a",  32'(busy_a), 0);
        check_eq("rst_done_a",  32'(done_a), 0);
        check_eq("rst_inc_a",   32'(inc_a), 0);
        check_eq("rst_valid_a", 32'(if_a.tx_valid), 0);
        check_eq("rst_data_a",  32'(if_a.tx_data), 0);
        check_eq("rst_valid_b", 32'(if_b.tx_valid), 0);
        check_eq("rst_busy_b",  32'(busy_b), 0);
        reset_n = 1'b0;
        @(negedge clk);

        // Fixed ROM, receiver always ready.
        rom_a[0] = 8'h12; rom_a[1] = 8'hAB; rom_a[2] = 8'h00; rom_a[3] = 8'hFF;
        mode_a = 0;
        run_a("t1");

        // Same ROM, ready pattern 1,0,0 repeating.
        mode_a = 1;
        run_a("t2");

        // Random ROMs with random backpressure.
        mode_a = 2;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) rom_a[i] = 8'($urandom);
            run_a($sformatf("t3_%0d", r));
        end

        // Reset while the ':' of record 1 is on the bus.
        rom_a[0] = 8'h12; rom_a[1] = 8'hAB; rom_a[2] = 8'h00; rom_a[3] = 8'hFF;
        mode_a = 0;
        prep_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            if (recs_a == 1 && if_a.tx_valid && if_a.tx_data == 8'h3A) found = 1;
        end
        check_eq("t4_colon_seen", 32'(found), 1);
        reset_n = 1'b1;
        #1;
        check_eq("t4_rst_valid", 32'(if_a.tx_valid), 0);
        check_eq("t4_rst_data",  32'(if_a.tx_data), 0);
        check_eq("t4_rst_busy",  32'(busy_a), 0);
        check_eq("t4_rst_inc",   32'(inc_a), 0);
        check_eq("t4_rst_done",  32'(done_a), 0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        run_a("t4");

        // start held high: one dump, then restart right after DONE.
        prep_a();
        start_a = 1'b1;
        @(negedge clk);
        wait_done_a("t5a", 2000);
        check_dump_a("t5a");
        rom_rst_a = 1'b1;
        q_a.delete(); recs_a = 0; pulses_a = 0;
        @(negedge clk);
        rom_rst_a = 1'b0;
        check_eq("t5_restart_busy", 32'(busy_a), 1);
        check_eq("t5_restart_done", 32'(done_a), 0);
        start_a = 1'b0;
        wait_done_a("t5b", 2000);
        check_dump_a("t5b");

        // Wide address, narrow data, random backpressure.
        begin
            int rom[$];
            for (int i = 0; i < 512; i++) rom_b[i] = 4'($urandom);
            rom_b[511] = 4'h7;
            for (int i = 0; i < 512; i++) rom.push_back(int'(rom_b[i]));
            mode_b = 2;
            rom_rst_b = 1'b1;
            @(negedge clk);
            rom_rst_b = 1'b0;
            q_b.delete(); recs_b = 0; pulses_b = 0;
            start_b = 1'b1;
            @(negedge clk);
            start_b = 1'b0;
            n = 0;
            while (!done_b && n < 40000) begin @(negedge clk); n++; end
            check_eq("t6_done_seen", 32'(done_b), 1);
            build_exp(B_AW, B_DW, rom);
            compare_stream("t6", q_b);
            check_eq("t6_pulses", pulses_b, 511);
            check_eq("t6_records", recs_b, 512 + TRAILER);
            if (q_b.size() >= 3584) begin
                check_eq("t6_last_a2", 32'(q_b[3577]), 'h31);
                check_eq("t6_last_a1", 32'(q_b[3578]), 'h46);
                check_eq("t6_last_a0", 32'(q_b[3579]), 'h46);
                check_eq("t6_last_col", 32'(q_b[3580]), 'h3A);
                check_eq("t6_last_d0", 32'(q_b[3581]), 'h37);
                check_eq("t6_last_cr", 32'(q_b[3582]), 'h0D);
                check_eq("t6_last_lf", 32'(q_b[3583]), 'h0A);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rom_dump_sequencer.md
Name: rom_dump_sequencer

Overview:
- Downstream consumer of rom_reader; automates a full chip dump.
- Steps rom_reader through every address via one-cycle increment pulses and waits a settle time per address.
- Per address: samples rom_reader's address_line/data_line and emits an ASCII record "AAA:DD\r\n" byte-by-byte on a valid/ready stream to the UART transmitter.
- Top level muxes its increment pulse with the manual button path.

Parameters:
DATA_WIDTH, 8, width of data_line from rom_reader (8 for 3604, 4 for 3601)
ADDRESS_WIDTH, 9, width of address_line from rom_reader (9 for 3604, 8 for 3601); legal 1..12
SETTLE_CYCLES, 4, clk cycles waited after entering an address before sampling; legal 1..255

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous reset, active-high (1 = reset); name kept consistent with rom_reader
start  in  1  level; sampled in IDLE/DONE, begins a dump
address_line  in  ADDRESS_WIDTH  current address from rom_reader
data_line  in  DATA_WIDTH  current data from rom_reader
increment_address  out  1  one-cycle pulse to rom_reader
tx_data  out  8  ASCII byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte
busy  out  1  high from start acceptance until DONE
done  out  1  high in DONE until next start or reset

Behaviour:
- Derived constants:
  - AD = ceil(ADDRESS_WIDTH/4) address hex digits.
  - DD = ceil(DATA_WIDTH/4) data hex digits.
  - Record length = AD+DD+3 bytes.
  - LAST = 2^ADDRESS_WIDTH-1.
- Reset (async, any state): state=IDLE, all outputs 0, captured regs 0, settle counter 0, digit index 0.
- Assumption: rom_reader itself is released from reset to address 0 by the top level before start.
- FSM states and transitions:
  - IDLE: busy=0, done=0. start=1 -> SETTLE, counter=0, busy=1 next cycle.
  - SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1 -> CAPTURE.
  - CAPTURE (1 cycle): latch address_line into cap_addr and data_line into cap_data -> EMIT, digit index 0.
  - EMIT:
    - tx_valid=1, tx_data = record byte[index].
    - Byte order: address hex digits MS first, ':' (0x3A), data hex digits MS first, CR (0x0D), LF (0x0A).
    - Hex digits are uppercase ('0'-'9' = 0x30-0x39, 'A'-'F' = 0x41-0x46); zero-extend upper nibble when width is not a multiple of 4.
    - On tx_valid&&tx_ready: index++. Next byte is presented the following cycle with tx_valid held high (back-to-back allowed, one byte/cycle max).
    - After LF is accepted: tx_valid=0; cap_addr==LAST -> DONE, else -> STEP.
  - STEP (1 cycle): increment_address=1 -> SETTLE, counter=0.
  - DONE: busy=0, done=1. start=1 -> SETTLE (new dump, busy=1, done=0); top level must reset rom_reader address first.
- Handshake rules: while tx_valid=1 and tx_ready=0, tx_data and tx_valid are held stable. tx_valid never drops without a transfer except on reset.
- start asserted while busy is ignored; start held high continuously re-triggers only from DONE.
- Wrap-around: the dump terminates on the captured address, never on a counter wrap; no increment pulse is issued after LAST. Exactly 2^ADDRESS_WIDTH records are emitted.
- Address source: the captured address comes from address_line, not an internal counter, so a mis-stepped rom_reader appears in the output.
- increment_address is exactly one cycle wide, once per record except the last.
- Reset mid-record: the stream is truncated with tx_valid dropping asynchronously; the transmitter must tolerate this.

Optional Feature:
- Macro: ROM_DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit accumulator (reset 0, cleared on start) adds zero-extended cap_data modulo 256 in each CAPTURE.
  - After the LAST record's LF, extra state CHKSUM emits "S:" (0x53,0x3A), two uppercase hex digits of the sum, CR, LF with the same handshake, then -> DONE.
- Undefined: no accumulator, no CHKSUM state; LAST record -> DONE directly.

Test Plan:
- Params ADDRESS_WIDTH=2, DATA_WIDTH=8, SETTLE_CYCLES=3; model ROM {0x12,0xAB,0x00,0xFF}; tx_ready=1; start pulse -> byte stream "0:12\r\n1:AB\r\n2:00\r\n3:FF\r\n", exactly 3 increment pulses, each followed by ≥3 settle cycles, then done=1, busy=0.
- Same ROM, tx_ready toggling 1,0,0,1...: tx_data/tx_valid stable during every stall; identical byte stream.
- DATA_WIDTH=4, ADDRESS_WIDTH=9, data=0x7 at 0x1FF -> last record "1FF:7\r\n"; 512 records total, 511 pulses.
- reset_n=1 asserted during the ':' byte of record 1 -> all outputs 0 in the same cycle; after release and start, the dump restarts cleanly from "0:".
- start held high throughout a dump -> no restart while busy; new dump begins the cycle after DONE.
- ROM_DUMP_CHECKSUM_EN defined, ROM from test 1 -> trailing "S:BC\r\n" (0x12+0xAB+0x00+0xFF = 0x1BC, sum 0xBC); macro undefined -> no trailer.
